// File: rtl/tmds_decoder.sv
// TMDS receive decoder: word alignment over a 20-bit sliding window, control token detection and 8b data recovery.
// Optional error counter (err_clr / err_cnt) is built only when TMDS_DEC_ERR_CNT_EN is defined.
module tmds_decoder #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  D,
  output logic [1:0]  c,
  output logic        de,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_DEC_ERR_CNT_EN
  ,
  input  logic        err_clr,
  output logic [15:0] err_cnt
`endif
);

  // state  | meaning
  // SEARCH | hunting for LOCK_TOKENS consecutive tokens at the current offset
  // LOCKED | aligned; decoded words are driven out
  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [9:0]        prev, win_r, win;
  logic [19:0]       pair;
  logic [4:0]        sel;
  logic [TOK_W-1:0]  tok_cnt, tok_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_nxt;
  logic [3:0]        offset_nxt;
  logic              is_tok;
  logic [1:0]        tok_c;
  logic [7:0]        d_inv, data;

  assign pair = {tmds_in, prev};
  assign sel  = {1'b0, offset};
  assign win  = pair[sel +: 10];

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (win_r)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion first, then the XOR/XNOR transition chain.
  always_comb begin
    d_inv   = win_r[9] ? ~win_r[7:0] : win_r[7:0];
    data    = '0;
    data[0] = d_inv[0];
    for (int i = 1; i < 8; i++)
      data[i] = win_r[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
  end

  always_comb begin
    state_nxt  = state;
    tok_nxt    = tok_cnt;
    tmo_nxt    = tmo_cnt;
    loss_nxt   = loss_cnt;
    offset_nxt = offset;
    if (state == SEARCH) begin
      if (is_tok) begin
        tmo_nxt = '0;
        if (tok_cnt < TOK_W'(LOCK_TOKENS)) tok_nxt = tok_cnt + TOK_W'(1);
        if (tok_nxt == TOK_W'(LOCK_TOKENS)) begin
          state_nxt = LOCKED;
          tok_nxt   = '0;
          loss_nxt  = '0;
        end
      end else begin
        tok_nxt = '0;
        if (tmo_cnt < TMO_W'(SEARCH_TIMEOUT)) tmo_nxt = tmo_cnt + TMO_W'(1);
        if (tmo_nxt == TMO_W'(SEARCH_TIMEOUT)) begin
          offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          tmo_nxt    = '0;
        end
      end
    end else begin
      if (is_tok) begin
        loss_nxt = '0;
      end else begin
        if (loss_cnt < LOSS_W'(LOSS_TIMEOUT)) loss_nxt = loss_cnt + LOSS_W'(1);
        if (loss_nxt == LOSS_W'(LOSS_TIMEOUT)) begin
          state_nxt = SEARCH;
          loss_nxt  = '0;
          tok_nxt   = '0;
          tmo_nxt   = '0;
        end
      end
    end
  end

  // Outputs follow the next state so the transition cycle already reflects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      prev     <= '0;
      win_r    <= '0;
      tok_cnt  <= '0;
      tmo_cnt  <= '0;
      loss_cnt <= '0;
      offset   <= '0;
      D        <= '0;
      c        <= '0;
      de       <= 1'b0;
      locked   <= 1'b0;
    end else begin
      prev     <= tmds_in;
      win_r    <= win;
      state    <= state_nxt;
      tok_cnt  <= tok_nxt;
      tmo_cnt  <= tmo_nxt;
      loss_cnt <= loss_nxt;
      offset   <= offset_nxt;
      locked   <= (state_nxt == LOCKED);
      if (state_nxt == LOCKED) begin
        de <= ~is_tok;
        D  <= is_tok ? 8'h00 : data;
        c  <= is_tok ? tok_c : 2'b00;
      end else begin
        de <= 1'b0;
        D  <= '0;
        c  <= '0;
      end
    end
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (state == LOCKED && state_nxt == SEARCH && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: a reference TMDS encoder feeds a bit stream at a chosen phase,
// and decoded symbols are compared against the queue of symbols that were encoded.
module tb_tmds_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  tmds_in = '0;
  logic [7:0]  D;
  logic [1:0]  c;
  logic        de, locked;
  logic [3:0]  offset;
`ifdef TMDS_DEC_ERR_CNT_EN
  logic        err_clr = 1'b0;
  logic [15:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  tmds_decoder #(.LOCK_TOKENS(4), .SEARCH_TIMEOUT(32), .LOSS_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .tmds_in(tmds_in), .D(D), .c(c), .de(de),
    .locked(locked), .offset(offset)
`ifdef TMDS_DEC_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference encoder running disparity
  int rd = 0;

  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (rd == 0 || n1q == n0q) begin
      q[9] = ~qm[8];
      q[8] = qm[8];
      q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      rd = rd + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      rd = rd + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      rd = rd - 2 * int'(!qm[8]) + n1q - n0q;
    end
    return q;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] t, input int s);
    logic [19:0] dbl;
    dbl = {t, t};
    return dbl[(10 - s) +: 10];
  endfunction

  // Stream generator: bit queue, symbol record, traffic state
  logic       qbits[$];
  bit         sym_ctl[$];
  logic [7:0] sym_val[$];
  int         word_idx;
  bit         gen_blank;
  int         gen_left;
  logic [1:0] gen_c;

  task automatic stream_init(input int s, input logic [1:0] cc);
    qbits.delete();
    sym_ctl.delete();
    sym_val.delete();
    word_idx  = 0;
    gen_blank = 1'b0;
    gen_left  = 0;
    gen_c     = cc;
    rd        = 0;
    for (int b = 0; b < s; b++) qbits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_symbol();
    logic [9:0] w;
    logic [7:0] byt;
    if (gen_left == 0) begin
      gen_blank = !gen_blank;
      gen_left  = gen_blank ? int'($urandom_range(8, 12)) : int'($urandom_range(8, 24));
      if (gen_blank) rd = 0;
    end
    if (gen_blank) begin
      w = TOK[gen_c];
      sym_ctl.push_back(1'b1);
      sym_val.push_back({6'b0, gen_c});
    end else begin
      byt = 8'($urandom);
      w = enc(byt);
      sym_ctl.push_back(1'b0);
      sym_val.push_back(byt);
    end
    gen_left--;
    for (int b = 0; b < 10; b++) qbits.push_back(w[b]);
  endtask

  task automatic step_const();
    @(posedge clk);
    #1;
  endtask

  task automatic step_stream();
    logic [9:0] w;
    while (qbits.size() < 10) push_symbol();
    for (int b = 0; b < 10; b++) w[b] = qbits.pop_front();
    tmds_in = w;
    word_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tmds_in = 10'h354;
    step_const();
    vectors++;
    if ({D, c, de, locked, offset} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got D=%h c=%b de=%b locked=%b offset=%0d want all 0", D, c, de, locked, offset);
    end
  endtask

  // Token 0x354 at offset 0: two reset-valued windows precede the first real token.
  task automatic test_lock_354();
    pulse_reset();
    tmds_in = 10'h354;
    for (int k = 1; k <= 6; k++) begin
      step_const();
      if (k == 5) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++;
          $display("FAIL lock354_early got locked=%b want 0", locked);
        end
      end
      if (k == 6) begin
        vectors++;
        if ({locked, de, c, offset} !== {1'b1, 1'b0, 2'b00, 4'd0}) begin
          miscompares++;
          $display("FAIL lock354 got locked=%b de=%b c=%b offset=%0d want 1 0 00 0", locked, de, c, offset);
        end
      end
    end
  endtask

  task automatic test_data_bytes();
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h55, 8'hA5};
    for (int i = 0; i < 4; i++) begin
      rd = 0;
      tmds_in = enc(bytes[i]);
      step_const();
      tmds_in = 10'h354;
      step_const();
      step_const();
      vectors++;
      if ({de, D} !== {1'b1, bytes[i]}) begin
        miscompares++;
        $display("FAIL data_byte%0d got de=%b D=%h want de=1 D=%h", i, de, D, bytes[i]);
      end
      step_const();
      vectors++;
      if ({de, c, locked} !== {1'b0, 2'b00, 1'b1}) begin
        miscompares++;
        $display("FAIL data_gap%0d got de=%b c=%b locked=%b want 0 00 1", i, de, c, locked);
      end
    end
  endtask

  task automatic test_loss();
    logic [7:0] b [70];
    rd = 0;
    for (int k = 0; k < 70; k++) begin
      b[k] = 8'($urandom);
      tmds_in = enc(b[k]);
      step_const();
      if (k >= 2 && k <= 64) begin
        vectors++;
        if ({locked, de, D} !== {1'b1, 1'b1, b[k-2]}) begin
          miscompares++;
          $display("FAIL loss_data k=%0d got locked=%b de=%b D=%h want 1 1 %h", k, locked, de, D, b[k-2]);
        end
      end
      if (k == 65) begin
        vectors++;
        if ({locked, de, D, c, offset} !== 16'h0) begin
          miscompares++;
          $display("FAIL loss_drop got locked=%b de=%b D=%h c=%b offset=%0d want all 0", locked, de, D, c, offset);
        end
`ifdef TMDS_DEC_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 16'd1) begin
          miscompares++;
          $display("FAIL err_cnt_inc got %0d want 1", err_cnt);
        end
`endif
      end
    end
`ifdef TMDS_DEC_ERR_CNT_EN
    err_clr = 1'b1;
    step_const();
    err_clr = 1'b0;
    vectors++;
    if (err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL err_cnt_clr got %0d want 0", err_cnt);
    end
`endif
  endtask

  // Token 0x2AB arriving 3 bits late: offsets 0..2 each time out after 32 non-token windows.
  task automatic test_search_rotate();
    pulse_reset();
    tmds_in = rotl(10'h2AB, 3);
    for (int k = 1; k <= 101; k++) begin
      step_const();
      if (k == 31 || k == 32 || k == 64 || k == 96) begin
        vectors++;
        if (offset !== ((k == 31) ? 4'd0 : 4'(k / 32))) begin
          miscompares++;
          $display("FAIL search_offset k=%0d got %0d want %0d", k, offset, (k == 31) ? 0 : k / 32);
        end
      end
      if (k == 100) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++;
          $display("FAIL search_early_lock got locked=%b want 0", locked);
        end
      end
      if (k == 101) begin
        vectors++;
        if ({locked, de, c, offset} !== {1'b1, 1'b0, 2'b11, 4'd3}) begin
          miscompares++;
          $display("FAIL search_lock got locked=%b de=%b c=%b offset=%0d want 1 0 11 3", locked, de, c, offset);
        end
      end
    end
  endtask

  task automatic test_reset_mid_search();
    pulse_reset();
    tmds_in = 10'h354;
    for (int k = 1; k <= 5; k++) step_const();
    rst = 1'b1;
    #1;
    vectors++;
    if ({D, c, de, locked, offset} !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs got D=%h c=%b de=%b locked=%b offset=%0d want all 0", D, c, de, locked, offset);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step_const();
      if (k == 5 || k == 6) begin
        vectors++;
        if (locked !== (k == 6)) begin
          miscompares++;
          $display("FAIL midrst_relock k=%0d got locked=%b want %0d", k, locked, k == 6);
        end
      end
    end
  endtask

  task automatic test_random_offsets();
    int n;
    bit got_lock;
    int q;
    logic [9:0] got, exp;
    for (int s = 0; s < 10; s++) begin
      rst = 1'b1;
      stream_init(s, 2'($urandom_range(0, 3)));
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_lock = 1'b0;
      for (n = 0; n < 3000 && !got_lock; n++) begin
        step_stream();
        got_lock = locked;
      end
      vectors++;
      if (!got_lock) begin
        miscompares++;
        $display("FAIL rand_lock s=%0d got locked=0 after %0d cycles want 1", s, n);
      end else begin
        vectors++;
        if (offset !== 4'(s)) begin
          miscompares++;
          $display("FAIL rand_offset got %0d want %0d", offset, s);
        end
        for (int k = 0; k < 150; k++) begin
          step_stream();
          q = word_idx - 3;
          got = {locked, de, de ? D : {6'b0, c}};
          exp = {1'b1, !sym_ctl[q], sym_ctl[q] ? {6'b0, sym_val[q][1:0]} : sym_val[q]};
          vectors++;
          if (got !== exp) begin
            miscompares++;
            $display("FAIL rand_decode s=%0d k=%0d got %h want %h", s, k, got, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_354();
    test_data_bytes();
    test_loss();
    test_search_rotate();
    test_reset_mid_search();
    test_random_offsets();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
